pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised, elastic inter-stage pipeline register. It generalises the fixed-field enable-gated stage latches (ID/EX, EX/MEM, MEM/WB) into one block with valid/ready handshake, stall, flush-to-bubble and an optional 2-entry skid buffer. Control and data payloads are opaque vectors; stages pack and unpack their own fields. It sits between any two pipeline stages and replaces the per-stage latch modules.

Parameters:
CTRL_W, 4, width of control payload (WB/M/EX bits); zeroed on bubble/flush
DATA_W, 69, width of data payload (e.g. 32+32+5); never cleared by flush
SKID, 1, 1 = 2-entry skid buffer with registered in_ready_o; 0 = single entry with combinational in_ready_o
RST_DATA, 1, 1 = data payload reset to 0; 0 = data payload not reset (area saving)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  synchronous flush: discard all held beats
in_valid_i  in  1  upstream beat valid
in_ready_o  out  1  stage can accept a beat this cycle
in_ctrl_i  in  CTRL_W  upstream control payload
in_data_i  in  DATA_W  upstream data payload
out_valid_o  out  1  downstream beat valid
out_ready_i  in  1  downstream accepts (0 = stall)
out_ctrl_o  out  CTRL_W  control payload, all-zero when out_valid_o=0
out_data_o  out  DATA_W  data payload
occ_o  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Transfer in: in_valid_i & in_ready_o at the edge. Transfer out: out_valid_o & out_ready_i at the edge.
- Latency: an accepted beat appears on out_* the next cycle when the stage is empty or draining.
- Reset (rst_i=1 at the edge): out_valid_o=0, out_ctrl_o=0, occ_o=0, skid entry invalid, out_data_o=0 if RST_DATA. in_ready_o=0 while rst_i=1; in_ready_o=1 the first cycle after reset. Reset mid-transfer drops all beats.
- Priority: rst_i > flush_i > normal operation.
- flush_i=1: next cycle both entries are invalid, out_ctrl_o=0 (bubble), data regs hold, occ_o=0. A beat presented in the flush cycle is dropped even if in_ready_o=1. in_ready_o=1 the next cycle.
- Bubble rule: out_ctrl_o is forced to zero whenever out_valid_o=0, so downstream sees a NOP regardless of handshake.
- Stall: out_valid_o=1 & out_ready_i=0 holds out_valid_o/out_ctrl_o/out_data_o stable.
- SKID=0:
  - in_ready_o = ~out_valid_o | out_ready_i (combinational).
  - On accept, the main entry loads; on out-transfer without accept, the main entry empties.
- SKID=1: main entry M (drives out_*) plus skid entry S. in_ready_o = ~S.valid (registered, no comb path from out_ready_i).
  - M empty or out-transfer: M loads from S if S.valid (S empties), else from the input if accepted, else M empties.
  - M full, no out-transfer, accept: beat goes to S.
  - Simultaneous accept and out-transfer with S valid: not possible, because in_ready_o=0.
  - Order is strictly FIFO.
- occ_o = M.valid + S.valid. It never reaches 3; a 2-to-3 attempt is impossible by construction and is asserted in simulation.
- Throughput: 1 beat/cycle sustained when out_ready_i=1 in both modes.

Decomposition:
- Package pipe_pkg: occupancy constants OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2, and a localparam helper for payload width sums. No typedefs, because payloads are opaque.
- Sub-module pipe_slot: one entry (valid, ctrl, data) with load, clear and flush inputs, and ctrl zeroing when invalid. Instantiate it once for M, and once more for S under SKID=1 via generate.

Test Plan:
- Reset: rst_i=1 for 2 cycles with in_valid_i=1 -> out_valid_o=0, out_ctrl_o=0, occ_o=0, in_ready_o=0; first post-reset cycle in_ready_o=1.
- Streaming: SKID=1, out_ready_i=1, send ctrl=0x1..0x8, data=0x100..0x107 back-to-back -> the same sequence appears 1 cycle later, 8 consecutive valid cycles, occ_o≤1.
- Stall/skid: SKID=1, send A(0x3,0xAA), B(0x5,0xBB), C(0x6,0xCC) with out_ready_i=0 from the cycle A is visible -> A held stable, B in skid, occ_o=2, in_ready_o=0, C not accepted until release; on release outputs are A, B, C in order.
- Flush: occ_o=2 and flush_i=1 with D valid at the input -> next cycle out_valid_o=0, out_ctrl_o=0, occ_o=0, D never appears, in_ready_o=1.
- SKID=0 pass-through: out_ready_i toggling 1,0,1 -> in_ready_o follows ~out_valid_o|out_ready_i in the same cycle, no beat lost or duplicated, occ_o never exceeds 1.
- Reset mid-stall: occ_o=2 and rst_i=1 for 1 cycle -> all entries are dropped and the outputs match the reset values.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline stage register.
package pipe_pkg;
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic int payload_w(input int a, input int b, input int c = 0);
    return a + b + c;
  endfunction
endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit, control payload (zeroed when invalid), data payload.
module pipe_slot #(
  parameter int CTRL_W   = 4,
  parameter int DATA_W   = 69,
  parameter bit RST_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);
  logic [CTRL_W-1:0] ctrl_q;

  // load beats clear so one entry can be drained and refilled in the same cycle
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_o <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      ctrl_q  <= ctrl_i;
    end else if (clear_i) begin
      valid_o <= 1'b0;
      ctrl_q  <= '0;
    end
  end

  assign ctrl_o = valid_o ? ctrl_q : '0;

  // data is never cleared by flush; the bubble is carried by valid/ctrl alone
  if (RST_DATA) begin : g_rst_data
    always_ff @(posedge clk_i) begin
      if (rst_i)                  data_o <= '0;
      else if (load_i && !flush_i) data_o <= data_i;
    end
  end else begin : g_nrst_data
    always_ff @(posedge clk_i) begin
      if (load_i && !rst_i && !flush_i) data_o <= data_i;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register: valid/ready handshake, stall, flush-to-bubble,
// optional 2-entry skid buffer that registers in_ready_o.
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int CTRL_W   = 4,
  parameter int DATA_W   = payload_w(32, 32, 5),
  parameter bit SKID     = 1'b1,
  parameter bit RST_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);
  logic              m_valid, s_valid, m_take, acc, m_load;
  logic [CTRL_W-1:0] s_ctrl, m_ctrl_d;
  logic [DATA_W-1:0] s_data, m_data_d;

  // main entry may take a new beat when empty or when its beat leaves this cycle
  assign m_take   = ~m_valid | out_ready_i;
  assign acc      = in_valid_i & in_ready_o & ~flush_i;
  assign m_load   = m_take & (s_valid | acc);
  assign m_ctrl_d = s_valid ? s_ctrl : in_ctrl_i;
  assign m_data_d = s_valid ? s_data : in_data_i;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_main (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .load_i  (m_load),
    .clear_i (m_take),
    .ctrl_i  (m_ctrl_d),
    .data_i  (m_data_d),
    .valid_o (m_valid),
    .ctrl_o  (out_ctrl_o),
    .data_o  (out_data_o)
  );

  assign out_valid_o = m_valid;

  if (SKID) begin : g_skid
    logic s_load;
    assign s_load     = ~m_take & acc;
    assign in_ready_o = ~s_valid & ~rst_i;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .load_i  (s_load),
      .clear_i (m_take),
      .ctrl_i  (in_ctrl_i),
      .data_i  (in_data_i),
      .valid_o (s_valid),
      .ctrl_o  (s_ctrl),
      .data_o  (s_data)
    );
  end else begin : g_noskid
    assign s_valid    = 1'b0;
    assign s_ctrl     = '0;
    assign s_data     = '0;
    assign in_ready_o = m_take & ~rst_i;
  end

  always_comb begin
    occ_o = OCC_EMPTY;
    case ({s_valid, m_valid})
      2'b01, 2'b10: occ_o = OCC_ONE;
      2'b11:        occ_o = OCC_FULL;
      default:      occ_o = OCC_EMPTY;
    endcase
  end

  // a third beat can never land: with both entries full in_ready_o is low
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(acc && s_valid && !m_take));
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: one SKID=0 and one SKID=1 stage share stimulus; a FIFO
// queue per stage is the reference model and is popped on each out-transfer.
module tb_pipe_stage_reg;
  localparam int CW = 4;
  localparam int DW = 69;
  localparam int W  = CW + DW;

  logic          clk = 1'b0;
  logic          rst, fl, in_v, out_rdy;
  logic [CW-1:0] in_c;
  logic [DW-1:0] in_d;
  int            derr = 0, dchk = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int SK = g;
    logic          rdy, ov;
    logic [CW-1:0] oc;
    logic [DW-1:0] od;
    logic [1:0]    occ;
    logic [W-1:0]  q[$];
    logic          pred_rdy;
    int            err = 0, chk = 0;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(g == 1), .RST_DATA(1'b1)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (fl),
      .in_valid_i  (in_v),
      .in_ready_o  (rdy),
      .in_ctrl_i   (in_c),
      .in_data_i   (in_d),
      .out_valid_o (ov),
      .out_ready_i (out_rdy),
      .out_ctrl_o  (oc),
      .out_data_o  (od),
      .occ_o       (occ)
    );

    task automatic ck(input string n, input logic [95:0] a, input logic [95:0] e);
      chk++;
      if (a !== e) begin
        err++;
        $display("FAIL %s skid=%0d got=%h exp=%h t=%0t", n, SK, a, e, $time);
      end
    endtask

    // stimulus side: a beat accepted at the edge is pushed; reset/flush empty the model
    always @(posedge clk) begin
      if (rst || fl) q.delete();
      else if (in_v && pred_rdy) q.push_back({in_c, in_d});
    end

    // monitor: compare handshake/occupancy each cycle, pop on every out-transfer
    always @(negedge clk) begin
      logic [W-1:0] e;
      pred_rdy = !rst && ((SK == 1) ? (q.size() < 2) : (q.size() == 0 || out_rdy));
      ck("in_ready", rdy, pred_rdy);
      ck("occ", occ, q.size());
      ck("out_valid", ov, q.size() != 0);
      if (!ov) ck("bubble_ctrl", oc, 0);
      if (ov && out_rdy && q.size() != 0) begin
        e = q.pop_front();
        ck("out_ctrl", oc, e[W-1:DW]);
        ck("out_data", od, e[DW-1:0]);
      end
    end
  end

  task automatic dck(input string n, input logic [95:0] a, input logic [95:0] e);
    dchk++;
    if (a !== e) begin
      derr++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic r, input logic f, input logic rs);
    @(posedge clk);
    #1;
    in_v = v; in_c = c; in_d = d; out_rdy = r; fl = f; rst = rs;
  endtask

  initial begin
    logic [95:0] r96;
    rst = 1'b1; fl = 1'b0; in_v = 1'b1; in_c = 4'hF; in_d = '1; out_rdy = 1'b1;

    // reset held two edges with a beat offered
    step(1'b1, 4'hF, '1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin end
    dck("rst_ready1", u[1].rdy, 0);
    dck("rst_occ1", u[1].occ, 0);
    dck("rst_data0", u[0].od, 0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    dck("post_rst_ready1", u[1].rdy, 1);
    dck("post_rst_ready0", u[0].rdy, 1);
    dck("post_rst_data1", u[1].od, 0);

    // back-to-back streaming
    for (int i = 0; i < 8; i++) step(1'b1, CW'(i + 1), DW'(32'h100 + i), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    dck("stream_last_ctrl", u[1].oc, 8);
    dck("stream_last_data", u[1].od, 32'h107);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // stall with skid: A held, B in skid, C waits for release
    step(1'b1, 4'h3, DW'(8'hAA), 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'h5, DW'(8'hBB), 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h6, DW'(8'hCC), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    dck("skid_occ", u[1].occ, 2);
    dck("skid_ready", u[1].rdy, 0);
    dck("skid_hold_ctrl", u[1].oc, 4'h3);
    dck("skid_hold_data", u[1].od, 8'hAA);
    step(1'b1, 4'h6, DW'(8'hCC), 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h6, DW'(8'hCC), 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'h6, DW'(8'hCC), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // flush with the skid full and D offered
    step(1'b1, 4'h7, DW'(8'h77), 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h8, DW'(8'h88), 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h9, DW'(8'h99), 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    dck("pre_flush_occ", u[1].occ, 2);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    dck("flush_valid", u[1].ov, 0);
    dck("flush_ctrl", u[1].oc, 0);
    dck("flush_occ", u[1].occ, 0);
    dck("flush_ready", u[1].rdy, 1);
    dck("flush_data_hold", u[1].od, 8'h77);

    // reset in the middle of a stall
    step(1'b1, 4'h1, DW'(8'h11), 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h2, DW'(8'h22), 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h3, DW'(8'h33), 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    dck("pre_rst_occ", u[1].occ, 2);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    dck("midrst_valid", u[1].ov, 0);
    dck("midrst_occ", u[1].occ, 0);
    dck("midrst_data", u[1].od, 0);
    dck("midrst_ready", u[1].rdy, 1);

    // random traffic with toggling backpressure, occasional flush/reset
    for (int i = 0; i < 3000; i++) begin
      r96 = {$urandom, $urandom, $urandom};
      step(($urandom % 4) != 0, CW'($urandom), r96[DW-1:0], ($urandom % 3) != 0,
           ($urandom % 40) == 0, ($urandom % 150) == 0);
    end

    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    dck("drain0", u[0].q.size(), 0);
    dck("drain1", u[1].q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             derr + u[0].err + u[1].err, dchk + u[0].chk + u[1].chk);
    $finish;
  end
endmodule
